// File: rtl/fp_norm_pack_pkg.sv
// Shared constants and state encoding for the floating-point add/sub back end.
//   MANT_W   : mantissa width including hidden bit
//   EXP_W    : biased exponent width
//   FRAC_W   : stored fraction width
//   MAG_W    : magnitude width (mantissa plus carry bit)
//   EXP_BIAS : IEEE-754 double exponent bias
//   EXP_INF  : all-ones exponent used for infinity
package fp_norm_pack_pkg;

    localparam int MANT_W = 53;
    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int MAG_W  = MANT_W + 1;

    localparam logic [EXP_W-1:0] EXP_BIAS = 11'd1023;
    localparam logic [EXP_W-1:0] EXP_INF  = 11'h7FF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_NORM = 2'd2,
        ST_PACK = 2'd3
    } state_t;

    // Two's-complement negation of a raw mantissa sum.
    function automatic logic [MANT_W-1:0] negate_mant(input logic [MANT_W-1:0] v);
        negate_mant = (~v) + {{(MANT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fp_norm_pack.sv
// fp_norm_pack: converts a raw two's-complement mantissa sum into
// sign-magnitude, normalizes it one bit per cycle and packs an IEEE-754 double.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   start  : one-cycle request, sampled only while idle
//   sum    : raw adder sum (MANT_W bits)
//   c_out  : raw adder carry out
//   op_sub : 1 = effective subtraction
//   sign_a : sign of operand A
//   exp_in : common aligned biased exponent (0 treated as 1)
//   result : packed double {sign, exp, frac}
//   done   : one-cycle pulse when result is valid
//   busy   : high while a job is in flight
module fp_norm_pack
    import fp_norm_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] sum,
    input  logic              c_out,
    input  logic              op_sub,
    input  logic              sign_a,
    input  logic [EXP_W-1:0]  exp_in,
    output logic [63:0]       result,
    output logic              done,
    output logic              busy
);

    state_t             state_r;
    logic [MANT_W-1:0]  sum_r;
    logic               c_out_r;
    logic               op_sub_r;
    logic               sign_r;
    logic [EXP_W-1:0]   exp_r;
    logic [MAG_W-1:0]   mag_r;
    logic               rs_r;
    logic               inf_r;
    logic [63:0]        result_r;
    logic               done_r;
    logic               busy_r;

    logic [MAG_W-1:0]   conv_mag_s;
    logic               conv_rs_s;
    logic [63:0]        pack_s;

    // Sign-magnitude recovery from the latched adder outputs.
    always_comb begin
        conv_mag_s = {MAG_W{1'b0}};
        conv_rs_s  = 1'b0;
        if (!op_sub_r) begin
            conv_mag_s = {c_out_r, sum_r};
            conv_rs_s  = sign_r;
        end else if (c_out_r) begin
            conv_mag_s = {1'b0, sum_r};
            conv_rs_s  = sign_r;
        end else begin
            // No carry on subtraction means B > A: result is negative.
            conv_mag_s = {1'b0, negate_mant(sum_r)};
            conv_rs_s  = ~sign_r;
        end
        // Exact cancellation always yields +0.
        if (conv_mag_s == {MAG_W{1'b0}}) begin
            conv_rs_s = 1'b0;
        end else begin
            conv_rs_s = conv_rs_s;
        end
    end

    // Final packing of sign, exponent and fraction.
    always_comb begin
        pack_s = 64'd0;
        if (inf_r) begin
            pack_s = {rs_r, EXP_INF, {FRAC_W{1'b0}}};
        end else if (mag_r == {MAG_W{1'b0}}) begin
            pack_s = 64'd0;
        end else if (!mag_r[FRAC_W]) begin
            // Hidden bit clear after normalization stopped at exp 1: denormal.
            pack_s = {rs_r, {EXP_W{1'b0}}, mag_r[FRAC_W-1:0]};
        end else begin
            pack_s = {rs_r, exp_r, mag_r[FRAC_W-1:0]};
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            sum_r    <= {MANT_W{1'b0}};
            c_out_r  <= 1'b0;
            op_sub_r <= 1'b0;
            sign_r   <= 1'b0;
            exp_r    <= {EXP_W{1'b0}};
            mag_r    <= {MAG_W{1'b0}};
            rs_r     <= 1'b0;
            inf_r    <= 1'b0;
            result_r <= 64'd0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        sum_r    <= sum;
                        c_out_r  <= c_out;
                        op_sub_r <= op_sub;
                        sign_r   <= sign_a;
                        exp_r    <= (exp_in == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_in;
                        inf_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_CONV;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    mag_r <= conv_mag_s;
                    rs_r  <= conv_rs_s;
                    if (conv_mag_s == {MAG_W{1'b0}}) begin
                        exp_r   <= {EXP_W{1'b0}};
                        state_r <= ST_PACK;
                    end else begin
                        state_r <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (mag_r[MAG_W-1]) begin
                        // Carry into bit 53: right shift, truncating the LSB.
                        mag_r <= mag_r >> 1;
                        exp_r <= exp_r + 11'd1;
                        if (exp_r == (EXP_INF - 11'd1)) begin
                            inf_r   <= 1'b1;
                            state_r <= ST_PACK;
                        end else begin
                            state_r <= ST_NORM;
                        end
                    end else if (!mag_r[FRAC_W] && (exp_r > 11'd1)) begin
                        mag_r <= mag_r << 1;
                        exp_r <= exp_r - 11'd1;
                    end else begin
                        state_r <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    result_r <= pack_s;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_r;
    assign done   = done_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed self-checking bench for fp_norm_pack.
module tb_fp_norm_pack;

    logic        clk;
    logic        rst;
    logic        start;
    logic [52:0] sum;
    logic        c_out;
    logic        op_sub;
    logic        sign_a;
    logic [10:0] exp_in;
    logic [63:0] result;
    logic        done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fp_norm_pack dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sum    (sum),
        .c_out  (c_out),
        .op_sub (op_sub),
        .sign_a (sign_a),
        .exp_in (exp_in),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one job and return the edge offset (from the accepting edge) at which done was seen.
    task automatic run_job(input logic [52:0] s, input logic c, input logic op,
                           input logic sa, input logic [10:0] e,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        sum = s; c_out = c; op_sub = op; sign_a = sa; exp_in = e; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        res = 64'd0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL job_timeout: done not seen after %0d edges, required within 200", lat);
        end
        res = result;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; sum = '0; c_out = 1'b0; op_sub = 1'b0; sign_a = 1'b0; exp_in = '0;
        #3;
        checks++;
        if ({result, done, busy} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state: result=%h done=%b busy=%b, required 0/0/0", result, done, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add;
        logic [63:0] r; int lat;
        run_job(53'h0, 1'b1, 1'b0, 1'b0, 11'd1023, r, lat);
        checks++;
        if (r !== 64'h4000000000000000) begin
            errors++; $display("FAIL add_1p1: result=%h, required 4000000000000000", r);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL add_latency: done after edge t+%0d, required t+4", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL add_busy_at_done: busy=%b, required 0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result !== 64'h4000000000000000) begin
            errors++; $display("FAIL result_hold: result=%h, required 4000000000000000", result);
        end
    endtask

    task automatic test_sub;
        logic [63:0] r; int lat;
        run_job(53'h08000000000000, 1'b1, 1'b1, 1'b0, 11'd1023, r, lat);
        checks++;
        if (r !== 64'h3FE0000000000000) begin
            errors++; $display("FAIL sub_pos: result=%h, required 3FE0000000000000", r);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL sub_pos_latency: t+%0d, required t+4", lat);
        end
        run_job(53'h18000000000000, 1'b0, 1'b1, 1'b0, 11'd1023, r, lat);
        checks++;
        if (r !== 64'hBFE0000000000000) begin
            errors++; $display("FAIL sub_neg: result=%h, required BFE0000000000000", r);
        end
    endtask

    task automatic test_boundaries;
        logic [63:0] r; int lat;
        run_job(53'h0, 1'b1, 1'b1, 1'b1, 11'd1023, r, lat);
        checks++;
        if (r !== 64'h0) begin
            errors++; $display("FAIL cancel_zero: result=%h, required 0", r);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL cancel_latency: t+%0d, required t+2", lat);
        end
        run_job(53'h0, 1'b1, 1'b0, 1'b0, 11'd2046, r, lat);
        checks++;
        if (r !== 64'h7FF0000000000000) begin
            errors++; $display("FAIL overflow_inf: result=%h, required 7FF0000000000000", r);
        end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL overflow_latency: t+%0d, required t+3", lat);
        end
        run_job(53'h1, 1'b1, 1'b1, 1'b0, 11'd3, r, lat);
        checks++;
        if (r !== 64'h0000000000000004) begin
            errors++; $display("FAIL denormal: result=%h, required 0000000000000004", r);
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL denormal_latency: t+%0d, required t+5", lat);
        end
        // Exponent 0 is treated as 1; already normalized, so no shift.
        run_job(53'h10000000000000, 1'b0, 1'b0, 1'b0, 11'd0, r, lat);
        checks++;
        if (r !== 64'h0010000000000000) begin
            errors++; $display("FAIL exp_zero_as_one: result=%h, required 0010000000000000", r);
        end
    endtask

    task automatic test_reset_mid_norm;
        int ndone;
        @(negedge clk);
        sum = 53'h1; c_out = 1'b1; op_sub = 1'b1; sign_a = 1'b0; exp_in = 11'd1023; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_mid_norm: busy=%b, required 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({result, done, busy} !== 66'd0) begin
            errors++; $display("FAIL async_reset: result=%h done=%b busy=%b, required 0/0/0", result, done, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++; $display("FAIL no_done_after_reset: %0d done pulses, required 0", ndone);
        end
    endtask

    task automatic test_start_while_busy;
        int ndone;
        @(negedge clk);
        sum = 53'h0; c_out = 1'b1; op_sub = 1'b0; sign_a = 1'b0; exp_in = 11'd1023; start = 1'b1;
        @(negedge clk);
        sum = 53'h1; c_out = 1'b1; op_sub = 1'b1; sign_a = 1'b1; exp_in = 11'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 1) begin
            errors++; $display("FAIL busy_ignore_count: %0d done pulses, required 1", ndone);
        end
        checks++;
        if (result !== 64'h4000000000000000) begin
            errors++; $display("FAIL busy_ignore_result: result=%h, required 4000000000000000", result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_boundaries();
        test_reset_mid_norm();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
